// File: rtl/rr_mux_2to1.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_2to1
// Purpose  : Two-source round-robin arbiter with a single registered output
//            stage. Emits the selected word plus a source tag (0 = A, 1 = B)
//            that steers a downstream mux_2to1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_valid_in,
  output logic             a_ready_out,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_valid_in,
  output logic             b_ready_out,
  output logic [WIDTH-1:0] y_out,
  output logic             y_valid_out,
  input  logic             y_ready_in,
  output logic             set_out
);

  typedef enum logic [0:0] {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

  pri_t pri_state;
  pri_t pri_next;

  logic load_en;
  logic grant_a;
  logic grant_b;
  logic take_a;
  logic take_b;

  // The output register can accept a new word when empty or being drained.
  assign load_en = !y_valid_out || y_ready_in;

  // Grant decision: a lone requester wins; on contention the priority state decides.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid_in && b_valid_in) begin
      grant_a = (pri_state == PRI_A);
      grant_b = (pri_state == PRI_B);
    end else begin
      grant_a = a_valid_in;
      grant_b = b_valid_in;
    end
  end

  // Readies are suppressed during reset so no handshake completes on a reset edge.
  assign a_ready_out = !rst_in && load_en && grant_a;
  assign b_ready_out = !rst_in && load_en && grant_b;

  assign take_a = a_valid_in && a_ready_out;
  assign take_b = b_valid_in && b_ready_out;

  // Priority next-state: favour the source that lost; hold when nothing transfers.
  always_comb begin
    pri_next = pri_state;
    if (take_a) begin
      pri_next = PRI_B;
    end else if (take_b) begin
      pri_next = PRI_A;
    end
  end

  // Priority state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pri_state <= PRI_A;
    end else begin
      pri_state <= pri_next;
    end
  end

  // Output stage: load the granted word, or empty when drained with nothing to load.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      y_out       <= '0;
      set_out     <= 1'b0;
      y_valid_out <= 1'b0;
    end else if (load_en) begin
      if (take_a) begin
        y_out       <= a_in;
        set_out     <= 1'b0;
        y_valid_out <= 1'b1;
      end else if (take_b) begin
        y_out       <= b_in;
        set_out     <= 1'b1;
        y_valid_out <= 1'b1;
      end else begin
        y_valid_out <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_2to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_2to1
// Purpose  : Self-checking bench for rr_mux_2to1: directed vectors followed by
//            a randomised valid/ready phase against a reference model and
//            an in-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_2to1;

  localparam int WIDTH = 8;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [WIDTH-1:0] a_in;
  logic             a_valid_in;
  logic             a_ready_out;
  logic [WIDTH-1:0] b_in;
  logic             b_valid_in;
  logic             b_ready_out;
  logic [WIDTH-1:0] y_out;
  logic             y_valid_out;
  logic             y_ready_in;
  logic             set_out;

  int checks = 0;
  int errors = 0;

  // Reference model state for the random phase.
  logic             m_valid;
  logic             m_pri;
  logic [WIDTH:0]   sb_q[$];
  int               starve_a;
  int               starve_b;

  rr_mux_2to1 #(.WIDTH(WIDTH)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .a_in        (a_in),
    .a_valid_in  (a_valid_in),
    .a_ready_out (a_ready_out),
    .b_in        (b_in),
    .b_valid_in  (b_valid_in),
    .b_ready_out (b_ready_out),
    .y_out       (y_out),
    .y_valid_out (y_valid_out),
    .y_ready_in  (y_ready_in),
    .set_out     (set_out)
  );

  // 10 ns clock.
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Apply inputs, let combinational paths settle.
  task automatic drive(input logic av, input logic [WIDTH-1:0] ad,
                       input logic bv, input logic [WIDTH-1:0] bd, input logic yr);
    a_valid_in = av;
    a_in       = ad;
    b_valid_in = bv;
    b_in       = bd;
    y_ready_in = yr;
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [WIDTH-1:0] d, input logic s);
    check({tag, "_valid"}, y_valid_out, v);
    check({tag, "_data"}, y_out, d);
    check({tag, "_tag"}, set_out, s);
  endtask

  // One random-phase cycle: check readies/valid against the model, score outputs.
  task automatic rcycle(input logic av, input logic bv, input logic yr);
    logic           load;
    logic           ga;
    logic           gb;
    logic [WIDTH:0] e;
    drive(av, WIDTH'($urandom), bv, WIDTH'($urandom), yr);
    load = !m_valid || yr;
    ga   = av && (!bv || (m_pri == 1'b0));
    gb   = bv && (!av || (m_pri == 1'b1));
    check("r_a_ready", a_ready_out, load && ga);
    check("r_b_ready", b_ready_out, load && gb);
    check("r_y_valid", y_valid_out, m_valid);
    if (y_valid_out && yr) begin
      if (sb_q.size() == 0) begin
        check("r_unexpected_word", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("r_data", y_out, e[WIDTH-1:0]);
        check("r_tag", set_out, e[WIDTH]);
      end
    end
    if (a_valid_in && a_ready_out) sb_q.push_back({1'b0, a_in});
    if (b_valid_in && b_ready_out) sb_q.push_back({1'b1, b_in});
    // Starvation: how many B wins occur while A waits, and vice versa.
    if (!av || (a_valid_in && a_ready_out)) starve_a = 0;
    else if (b_valid_in && b_ready_out) starve_a++;
    if (!bv || (b_valid_in && b_ready_out)) starve_b = 0;
    else if (a_valid_in && a_ready_out) starve_b++;
    check("r_starve_a", starve_a <= 1, 1);
    check("r_starve_b", starve_b <= 1, 1);
    if (load) begin
      m_valid = ga || gb;
      if (ga) m_pri = 1'b1;
      else if (gb) m_pri = 1'b0;
    end
    tick();
  endtask

  // Stimulus: directed vectors, then randomised traffic.
  initial begin
    rst_in = 1'b1;
    drive(1'b1, 8'h33, 1'b1, 8'h44, 1'b1);
    check("rst_a_ready", a_ready_out, 0);
    check("rst_b_ready", b_ready_out, 0);
    tick();
    tick();

    // Reset then idle.
    rst_in = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check_out("idle", 1'b0, 8'h00, 1'b0);
    check("idle_a_ready", a_ready_out, 0);
    check("idle_b_ready", b_ready_out, 0);

    // Single A word.
    drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    check("a_only_a_ready", a_ready_out, 1);
    check("a_only_b_ready", b_ready_out, 0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check_out("a_only", 1'b1, 8'h11, 1'b0);
    tick();
    // Drained with nothing to load: valid drops, data and tag hold.
    check_out("drain", 1'b0, 8'h11, 1'b0);

    // Single B word (priority now favours A again afterwards).
    drive(1'b0, 8'h00, 1'b1, 8'h22, 1'b1);
    check("b_only_b_ready", b_ready_out, 1);
    check("b_only_a_ready", a_ready_out, 0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check_out("b_only", 1'b1, 8'h22, 1'b1);
    tick();

    // Both continuously valid: strict alternation, one word per cycle.
    drive(1'b1, 8'hA5, 1'b1, 8'h5A, 1'b1);
    check("alt_a_ready0", a_ready_out, 1);
    check("alt_b_ready0", b_ready_out, 0);
    tick();
    check_out("alt0", 1'b1, 8'hA5, 1'b0);
    check("alt_b_ready1", b_ready_out, 1);
    tick();
    check_out("alt1", 1'b1, 8'h5A, 1'b1);
    tick();
    check_out("alt2", 1'b1, 8'hA5, 1'b0);
    tick();
    check_out("alt3", 1'b1, 8'h5A, 1'b1);

    // Backpressure for three cycles: output stable, no readies.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hA5, 1'b1, 8'h5A, 1'b0);
      check_out("hold", 1'b1, 8'h5A, 1'b1);
      check("hold_a_ready", a_ready_out, 0);
      check("hold_b_ready", b_ready_out, 0);
      tick();
    end
    drive(1'b1, 8'hA5, 1'b1, 8'h5A, 1'b1);
    check("release_a_ready", a_ready_out, 1);
    check("release_b_ready", b_ready_out, 0);
    tick();
    check_out("release", 1'b1, 8'hA5, 1'b0);
    tick();
    check_out("pre_rst", 1'b1, 8'h5A, 1'b1);

    // Reset while holding a word: word discarded, priority back to A.
    rst_in = 1'b1;
    drive(1'b1, 8'hA5, 1'b1, 8'h5A, 1'b0);
    check("midrst_a_ready", a_ready_out, 0);
    check("midrst_b_ready", b_ready_out, 0);
    tick();
    rst_in = 1'b0;
    drive(1'b1, 8'hA5, 1'b1, 8'h5A, 1'b1);
    check_out("post_rst", 1'b0, 8'h00, 1'b0);
    check("post_rst_a_ready", a_ready_out, 1);
    check("post_rst_b_ready", b_ready_out, 0);
    tick();
    check_out("post_rst_first", 1'b1, 8'hA5, 1'b0);

    // Random phase from a clean reset.
    rst_in = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    rst_in   = 1'b0;
    m_valid  = 1'b0;
    m_pri    = 1'b0;
    starve_a = 0;
    starve_b = 0;
    for (int i = 0; i < 1000; i++) begin
      rcycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3; i++) begin
      rcycle(1'b0, 1'b0, 1'b1);
    end
    check("r_queue_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_mux_2to1.md
RR_MUX_2TO1 -- requirements
Module: rr_mux_2to1

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data width of both source channels and the output.
REQ-002 SHALL provide port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_in, input, 1, reset; synchronous and active-high.
REQ-004 SHALL provide port a_in, input, WIDTH, source A data word.
REQ-005 SHALL provide port a_valid_in, input, 1, source A word available.
REQ-006 SHALL provide port a_ready_out, output, 1, source A word accepted this cycle when high together with a_valid_in.
REQ-007 SHALL provide port b_in, input, WIDTH, source B data word.
REQ-008 SHALL provide port b_valid_in, input, 1, source B word available.
REQ-009 SHALL provide port b_ready_out, output, 1, source B word accepted this cycle when high together with b_valid_in.
REQ-010 SHALL provide port y_out, output, WIDTH, registered selected word.
REQ-011 SHALL provide port y_valid_out, output, 1, y_out holds a valid word.
REQ-012 SHALL provide port y_ready_in, input, 1, downstream consumes y_out when high together with y_valid_out.
REQ-013 SHALL provide port set_out, output, 1, registered source tag of y_out (0 = A, 1 = B); it drives the set_in select of the downstream mux_2to1.

Function
REQ-014 SHALL hold one output register (y_out, set_out, y_valid_out); load_en = !y_valid_out || y_ready_in.
REQ-015 SHALL keep a one-bit priority FSM with states PRI_A and PRI_B.
REQ-016 Grant rule: only A valid -> grant A; only B valid -> grant B; both valid -> grant A in PRI_A, grant B in PRI_B; neither valid -> no grant.
REQ-017 a_ready_out SHALL equal load_en && grant A; b_ready_out SHALL equal load_en && grant B. These are combinational, and at most one is high per cycle.
REQ-018 On an accepted transfer, the next edge SHALL load y_out with the granted word, set set_out to the granted tag, and set y_valid_out to 1. Latency is 1 cycle from acceptance to y_valid_out.
REQ-019 If load_en is high and no source is valid while y_ready_in drains the register, y_valid_out SHALL go to 0. y_out and set_out SHALL hold their last values.
REQ-020 While y_valid_out=1 and y_ready_in=0, y_out and set_out SHALL be stable and both ready outputs SHALL be 0.
REQ-021 Simultaneous drain and load in one cycle SHALL sustain one word per cycle with no bubble.
REQ-022 After each accepted transfer, the FSM SHALL move to the state favouring the non-granted source: grant A -> PRI_B, grant B -> PRI_A. With no transfer it SHALL hold state.
REQ-023 Both sources continuously valid with y_ready_in=1 SHALL produce strict alternation A,B,A,B...
REQ-024 No word SHALL be duplicated or dropped: each accepted handshake yields exactly one y_out handshake, in acceptance order.

Reset
REQ-025 rst_in=1 at an edge SHALL force y_valid_out=0, y_out=0, set_out=0 and FSM=PRI_A. This applies regardless of other inputs.
REQ-026 While rst_in=1, a_ready_out and b_ready_out SHALL be 0.
REQ-027 Reset mid-operation SHALL discard any held word without a downstream handshake. The first post-reset grant with both sources valid SHALL go to A.

Verification
REQ-028 Reset then idle -> y_valid_out=0, y_out=0x00, set_out=0, both ready outputs=1 only when the matching valid is high.
REQ-029 a_in=0x11 valid alone, y_ready_in=1 -> next cycle y_out=0x11, set_out=0, y_valid_out=1.
REQ-030 Both valid continuously (a_in=0xA5, b_in=0x5A), y_ready_in=1 -> output sequence 0xA5/0, 0x5A/1, 0xA5/0, 0x5A/1, one word per cycle.
REQ-031 Output held with y_ready_in=0 for 3 cycles while both sources valid -> y_out and set_out stable, both ready outputs=0. On y_ready_in=1, the next word follows the priority state.
REQ-032 rst_in pulsed while y_valid_out=1 with y_out=0x5A, set_out=1 -> next cycle y_valid_out=0, y_out=0x00. With both sources then valid, the first output is the A word.
REQ-033 Randomised valid/ready for 1000 cycles -> scoreboard shows no loss, no duplication, set_out matching the source of every word, and no source starved for more than 1 accepted transfer while valid.
